// File: rtl/mem_arb_pkg.sv
// Shared encodings for the mem_arbiter byte-serialising RAM arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // The reserved length code is treated as a full word.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_to_bytes = 3'd1;
            LEN_H:   len_to_bytes = 3'd2;
            LEN_W:   len_to_bytes = 3'd4;
            default: len_to_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_byte_asm.sv
// Little-endian word assembly register: clears at grant and loads one byte lane per read acknowledge.
module mem_arb_byte_asm #(
    parameter int M_DATA_L = 8,
    parameter int C_DATA_L = 32,
    parameter int LANE_W   = $clog2(C_DATA_L / M_DATA_L)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [LANE_W-1:0]   lane,
    input  logic [M_DATA_L-1:0] byte_in,
    output logic [C_DATA_L-1:0] word
);

    logic [C_DATA_L-1:0] word_q;

    // The output already includes this cycle's byte, so the final lane can be committed on its ack edge.
    always_comb begin
        word = word_q;
        if (clear) begin
            word = '0;
        end else if (load) begin
            word[int'(lane) * M_DATA_L +: M_DATA_L] = byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
        end else begin
            word_q <= word;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising fetch and load/store accesses onto a byte-wide RAM port.
// Define ARB_RR_EN for round-robin tie-breaking; by default port 1 always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MADDR_L  = 32,
    parameter int M_DATA_L = 8,
    parameter int C_DATA_L = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [MADDR_L-1:0]  i_addr,
    output logic [C_DATA_L-1:0] i_rdata,
    output logic                i_done,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_len,
    input  logic [MADDR_L-1:0]  d_addr,
    input  logic [C_DATA_L-1:0] d_wdata,
    output logic [C_DATA_L-1:0] d_rdata,
    output logic                d_done,
    output logic [MADDR_L-1:0]  m_raddr,
    output logic [MADDR_L-1:0]  m_waddr,
    output logic                m_re,
    output logic                m_we,
    output logic [M_DATA_L-1:0] m_din,
    input  logic [M_DATA_L-1:0] m_dout,
    input  logic                m_rack,
    input  logic                m_wack
);

    localparam int LANE_W = $clog2(C_DATA_L / M_DATA_L);

    arb_state_t          state_q, state_d;
    logic                port_q;
    logic                we_q;
    logic [LANE_W-1:0]   idx_q;
    logic [2:0]          nbytes_q;
    logic [C_DATA_L-1:0] wdata_q;
    logic [MADDR_L-1:0]  raddr_q, waddr_q;
    logic [C_DATA_L-1:0] i_rdata_q, d_rdata_q;
    logic [C_DATA_L-1:0] asm_word;
    logic                any_req, grant_d, ack, last;

    assign any_req = i_req | d_req;
    assign ack     = we_q ? m_wack : m_rack;
    assign last    = ({1'b0, idx_q} == (nbytes_q - 3'd1));

`ifdef ARB_RR_EN
    logic rr_q;

    // Pointer names the preferred port on a tie and hands preference to the other port after each grant.
    assign grant_d = d_req && (!i_req || rr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b1;
        end else if (state_q == DONE) begin
            rr_q <= ~port_q;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = XFER;
            XFER:    if (ack && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_re    = (state_q == XFER) && !we_q;
    assign m_we    = (state_q == XFER) && we_q;
    assign m_din   = wdata_q[int'(idx_q) * M_DATA_L +: M_DATA_L];
    assign m_raddr = raddr_q;
    assign m_waddr = waddr_q;
    assign i_done  = (state_q == DONE) && !port_q;
    assign d_done  = (state_q == DONE) && port_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    mem_arb_byte_asm #(
        .M_DATA_L(M_DATA_L),
        .C_DATA_L(C_DATA_L),
        .LANE_W  (LANE_W)
    ) u_asm (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_q == IDLE) && any_req),
        .load   ((state_q == XFER) && !we_q && m_rack),
        .lane   (idx_q),
        .byte_in(m_dout),
        .word   (asm_word)
    );

    // Address registers advance only on an acknowledge, so an address not in use keeps its last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            nbytes_q  <= 3'd0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q   <= grant_d;
                        we_q     <= grant_d & d_we;
                        nbytes_q <= grant_d ? len_to_bytes(d_len) : 3'd4;
                        wdata_q  <= grant_d ? d_wdata : '0;
                        idx_q    <= '0;
                        if (grant_d && d_we) begin
                            waddr_q <= d_addr;
                        end else begin
                            raddr_q <= grant_d ? d_addr : i_addr;
                        end
                    end
                end
                XFER: begin
                    if (ack) begin
                        if (last) begin
                            if (!we_q) begin
                                if (port_q) d_rdata_q <= asm_word;
                                else        i_rdata_q <= asm_word;
                            end
                        end else begin
                            idx_q <= idx_q + LANE_W'(1);
                            if (we_q) waddr_q <= waddr_q + MADDR_L'(1);
                            else      raddr_q <= raddr_q + MADDR_L'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a byte RAM model of programmable acknowledge latency.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        i_req, i_done, d_req, d_we, d_done;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_raddr, m_waddr;
    logic [1:0]  d_len;
    logic        m_re, m_we, m_rack, m_wack;
    logic [7:0]  m_din, m_dout;

    int checks;
    int errors;
    int rack_lat;
    logic load_mem;
    logic [7:0] mem [256];
    int wait_cnt;
    logic [31:0] rd_log [$];
    logic [31:0] wr_addr_log [$];
    logic [7:0]  wr_data_log [$];
    int stall_err, both_err;
    logic prev_re, prev_ack;
    logic [31:0] prev_raddr;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_word_q [$];
    bit          exp_port_q [$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_re(m_re), .m_we(m_we), .m_din(m_din),
        .m_dout(m_dout), .m_rack(m_rack), .m_wack(m_wack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // RAM model: acknowledge in the rack_lat-th cycle of a strobe; memory indexed by the low address byte.
    assign m_rack = m_re && (wait_cnt == rack_lat - 1);
    assign m_wack = m_we && (wait_cnt == rack_lat - 1);
    assign m_dout = mem[m_raddr[7:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= pat(8'(a));
            mem[8'h10] <= 8'h78;
            mem[8'h11] <= 8'h56;
            mem[8'h12] <= 8'h34;
            mem[8'h13] <= 8'h12;
            mem[8'hFF] <= 8'h34;
            mem[8'h00] <= 8'h12;
        end else if (m_we && m_wack) begin
            mem[m_waddr[7:0]] <= m_din;
        end
        if ((m_re || m_we) && !(m_rack || m_wack)) wait_cnt <= wait_cnt + 1;
        else                                       wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (m_re && m_rack) rd_log.push_back(m_raddr);
        if (m_we && m_wack) begin
            wr_addr_log.push_back(m_waddr);
            wr_data_log.push_back(m_din);
        end
        if (m_re && m_we) both_err <= both_err + 1;
        if (m_re && prev_re && !prev_ack && (m_raddr != prev_raddr)) stall_err <= stall_err + 1;
        prev_re    <= m_re;
        prev_ack   <= m_rack;
        prev_raddr <= m_raddr;
    end

    // Counts negedges from the request drive; the request cycle itself is the first cycle of latency.
    task automatic wait_done(input bit port, input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            cycles++;
            if ((port && d_done) || (!port && i_done)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_len = 2'd0;
        i_addr = '0; d_addr = '0; d_wdata = '0; rack_lat = 1; load_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        checks++;
        if ({m_re, m_we, i_done, d_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000", {m_re, m_we, i_done, d_done});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", i_rdata, d_rdata);
        end
        checks++;
        if ({m_raddr, m_waddr, m_din} !== 72'h0) begin
            errors++;
            $display("[TB] FAIL reset_ram_port: got %h %h %h expected 0", m_raddr, m_waddr, m_din);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        int cycles, base;
        bit ok;
        logic [31:0] exp;
        base = rd_log.size();
        rack_lat = 1;
        for (int n = 0; n < 4; n++) exp_addr_q.push_back(32'h10 + 32'(n));
        exp_word_q.push_back(32'h12345678);
        i_addr = 32'h10;
        i_req = 1'b1;
        wait_done(1'b0, 40, cycles, ok);
        i_req = 1'b0;
        checks++;
        if (!ok || (cycles + 1) != 6) begin
            errors++;
            $display("[TB] FAIL fetch_latency: got done=%0d lat=%0d expected done=1 lat=6", ok, cycles + 1);
        end
        exp = exp_word_q.pop_front();
        checks++;
        if (i_rdata !== exp) begin
            errors++;
            $display("[TB] FAIL fetch_rdata: got %h expected %h", i_rdata, exp);
        end
        for (int n = 0; n < 4; n++) begin
            exp = exp_addr_q.pop_front();
            checks++;
            if (rd_log.size() <= base + n) begin
                errors++;
                $display("[TB] FAIL fetch_addr%0d: got none expected %h", n, exp);
            end else if (rd_log[base + n] !== exp) begin
                errors++;
                $display("[TB] FAIL fetch_addr%0d: got %h expected %h", n, rd_log[base + n], exp);
            end
        end
        @(negedge clk);
        checks++;
        if (i_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_pulse: got %b expected 0", i_done);
        end
    endtask

    task automatic test_store_byte;
        int cycles, base;
        bit ok;
        logic [31:0] exp;
        base = wr_addr_log.size();
        exp_addr_q.push_back(32'h20);
        exp_word_q.push_back(32'h000000DD);
        d_we = 1'b1; d_len = 2'd0; d_addr = 32'h20; d_wdata = 32'hAABBCCDD;
        d_req = 1'b1;
        wait_done(1'b1, 40, cycles, ok);
        d_req = 1'b0;
        d_we = 1'b0;
        checks++;
        if (!ok || (cycles + 1) != 3) begin
            errors++;
            $display("[TB] FAIL store_latency: got done=%0d lat=%0d expected done=1 lat=3", ok, cycles + 1);
        end
        checks++;
        if (wr_addr_log.size() - base != 1) begin
            errors++;
            $display("[TB] FAIL store_count: got %0d expected 1", wr_addr_log.size() - base);
        end else begin
            exp = exp_addr_q.pop_front();
            checks++;
            if (wr_addr_log[base] !== exp) begin
                errors++;
                $display("[TB] FAIL store_addr: got %h expected %h", wr_addr_log[base], exp);
            end
            exp = exp_word_q.pop_front();
            checks++;
            if (wr_data_log[base] !== exp[7:0]) begin
                errors++;
                $display("[TB] FAIL store_data: got %h expected %h", wr_data_log[base], exp[7:0]);
            end
        end
        checks++;
        if (mem[8'h21] !== pat(8'h21)) begin
            errors++;
            $display("[TB] FAIL store_neighbour: got %h expected %h", mem[8'h21], pat(8'h21));
        end
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_pulse: got %b expected 0", d_done);
        end
    endtask

    task automatic test_half_wrap;
        int cycles, base;
        bit ok;
        logic [31:0] exp;
        base = rd_log.size();
        exp_addr_q.push_back(32'hFFFFFFFF);
        exp_addr_q.push_back(32'h00000000);
        exp_word_q.push_back(32'h00001234);
        d_we = 1'b0; d_len = 2'd1; d_addr = 32'hFFFFFFFF;
        d_req = 1'b1;
        wait_done(1'b1, 40, cycles, ok);
        d_req = 1'b0;
        checks++;
        if (!ok || (cycles + 1) != 4) begin
            errors++;
            $display("[TB] FAIL half_latency: got done=%0d lat=%0d expected done=1 lat=4", ok, cycles + 1);
        end
        exp = exp_word_q.pop_front();
        checks++;
        if (d_rdata !== exp) begin
            errors++;
            $display("[TB] FAIL half_rdata: got %h expected %h", d_rdata, exp);
        end
        for (int n = 0; n < 2; n++) begin
            exp = exp_addr_q.pop_front();
            checks++;
            if (rd_log.size() <= base + n) begin
                errors++;
                $display("[TB] FAIL half_addr%0d: got none expected %h", n, exp);
            end else if (rd_log[base + n] !== exp) begin
                errors++;
                $display("[TB] FAIL half_addr%0d: got %h expected %h", n, rd_log[base + n], exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cycles, base, pulses;
        bit ok;
        base = rd_log.size();
        pulses = 0;
        rack_lat = 1;
        i_addr = 32'h10;
        i_req = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rd_log.size() - base >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL midreset_progress: got %0d bytes expected 2", rd_log.size() - base);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_re !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_strobe: got %b expected 0", m_re);
        end
        checks++;
        if (i_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_rdata: got %h expected 0", i_rdata);
        end
        repeat (3) begin
            @(negedge clk);
            if (i_done) pulses++;
        end
        checks++;
        if (pulses != 0 || rd_log.size() - base != 2) begin
            errors++;
            $display("[TB] FAIL midreset_abandon: got pulses=%0d bytes=%0d expected 0 2", pulses, rd_log.size() - base);
        end
        base = rd_log.size();
        rst = 1'b1;
        wait_done(1'b0, 40, cycles, ok);
        i_req = 1'b0;
        checks++;
        if (!ok || (cycles + 1) != 6) begin
            errors++;
            $display("[TB] FAIL restart_latency: got done=%0d lat=%0d expected done=1 lat=6", ok, cycles + 1);
        end
        checks++;
        if (rd_log.size() <= base || rd_log[base] !== 32'h10) begin
            errors++;
            $display("[TB] FAIL restart_first_addr: got %h expected 00000010", (rd_log.size() > base) ? rd_log[base] : 32'hX);
        end
        checks++;
        if (i_rdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL restart_rdata: got %h expected 12345678", i_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        int cycles, base, stall_base, both_base;
        bit ok;
        logic [31:0] exp;
        base = rd_log.size();
        stall_base = stall_err;
        both_base = both_err;
        rack_lat = 5;
        for (int n = 0; n < 4; n++) exp_addr_q.push_back(32'h30 + 32'(n));
        exp_word_q.push_back({pat(8'h33), pat(8'h32), pat(8'h31), pat(8'h30)});
        i_addr = 32'h30;
        i_req = 1'b1;
        wait_done(1'b0, 80, cycles, ok);
        i_req = 1'b0;
        checks++;
        if (!ok || (cycles + 1) != 22) begin
            errors++;
            $display("[TB] FAIL stall_latency: got done=%0d lat=%0d expected done=1 lat=22", ok, cycles + 1);
        end
        exp = exp_word_q.pop_front();
        checks++;
        if (i_rdata !== exp) begin
            errors++;
            $display("[TB] FAIL stall_rdata: got %h expected %h", i_rdata, exp);
        end
        for (int n = 0; n < 4; n++) begin
            exp = exp_addr_q.pop_front();
            checks++;
            if (rd_log.size() <= base + n || rd_log[base + n] !== exp) begin
                errors++;
                $display("[TB] FAIL stall_addr%0d: got %h expected %h", n, (rd_log.size() > base + n) ? rd_log[base + n] : 32'hX, exp);
            end
        end
        checks++;
        if (stall_err - stall_base != 0 || both_err - both_base != 0) begin
            errors++;
            $display("[TB] FAIL stall_stability: got moves=%0d overlaps=%0d expected 0 0", stall_err - stall_base, both_err - both_base);
        end
        rack_lat = 1;
        @(negedge clk);
    endtask

    task automatic test_contention;
        int gap;
        bit ok, port, exp_port;
        logic [31:0] i_word, d_word, got;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_word = {pat(8'h43), pat(8'h42), pat(8'h41), pat(8'h40)};
        d_word = {pat(8'h53), pat(8'h52), pat(8'h51), pat(8'h50)};
`ifdef ARB_RR_EN
        exp_port_q.push_back(1'b1); exp_port_q.push_back(1'b0);
        exp_port_q.push_back(1'b1); exp_port_q.push_back(1'b0);
`else
        for (int n = 0; n < 4; n++) exp_port_q.push_back(1'b1);
`endif
        i_addr = 32'h40;
        d_addr = 32'h50; d_we = 1'b0; d_len = 2'd2;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            ok = 1'b0;
            gap = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                gap++;
                if (i_done || d_done) begin
                    ok = 1'b1;
                    break;
                end
            end
            exp_port = exp_port_q.pop_front();
            port = d_done;
            got = port ? d_rdata : i_rdata;
            checks++;
            if (!ok || port != exp_port) begin
                errors++;
                $display("[TB] FAIL grant%0d_port: got done=%0d port=%0d expected port=%0d", g, ok, port, exp_port);
            end
            checks++;
            if (got !== (exp_port ? d_word : i_word)) begin
                errors++;
                $display("[TB] FAIL grant%0d_rdata: got %h expected %h", g, got, exp_port ? d_word : i_word);
            end
            if (g > 0) begin
                checks++;
                if (gap != 6) begin
                    errors++;
                    $display("[TB] FAIL grant%0d_gap: got %0d expected 6", g, gap);
                end
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_fetch;
        test_store_byte;
        test_half_wrap;
        test_reset_mid;
        test_stall;
        test_contention;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
